// File: rtl/ram_b_pkg.sv
// Shared constants for the data-RAM arbiter: default widths, depth and FSM state encoding.
package ram_b_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RAM_DW = 48;
  localparam int DEF_DEPTH  = 128;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam int PORT_CPU  = 0;
  localparam int PORT_UART = 1;

endpackage

// File: rtl/ram_b_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, on contention the port that was not
// granted last time wins.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_gnt,
  output logic       o_any,
  output logic       o_id
);

  assign o_any = |i_req;
  assign o_id  = (i_req == 2'b11) ? ~i_last_gnt : i_req[1];

endmodule

// File: rtl/ram_b_arbiter.sv
// Round-robin arbiter and access sequencer for the single-port data RAM shared by the CPU
// (port 0) and the UART writeback engine (port 1).
//
// state | meaning
// IDLE  | waiting for a request; winner's address/data/we registered onto the RAM port
// ISSUE | RAM samples the registered port at the closing edge; ram_we dropped
// RESP  | RAM read data valid; ack and rdata registered for the granted port
module ram_b_arbiter
  import ram_b_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RAM_DW = DEF_RAM_DW,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_din,
  output logic              o_ram_we,
  input  logic [RAM_DW-1:0] i_ram_dout
);

  logic [1:0]        r_state;
  logic              r_last_gnt;
  logic              r_gnt_id;
  logic              r_we;
  logic              r_inr;
  logic              r_ack0;
  logic              r_ack1;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_din;
  logic              r_ram_we;

  logic              w_any;
  logic              w_id;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_inr;
  logic              w_unused_hi;

  rr_arb2 u_arb (
    .i_req      ({i_req1, i_req0}),
    .i_last_gnt (r_last_gnt),
    .o_any      (w_any),
    .o_id       (w_id)
  );

  assign w_sel_we    = w_id ? i_we1    : i_we0;
  assign w_sel_addr  = w_id ? i_addr1  : i_addr0;
  assign w_sel_wdata = w_id ? i_wdata1 : i_wdata0;
  assign w_sel_inr   = (w_sel_addr < ADDR_W'(DEPTH));

  // The RAM's upper read bits carry nothing for this bus.
  assign w_unused_hi = ^i_ram_dout[RAM_DW-1:DATA_W];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= 1'b1;
      r_gnt_id   <= 1'b0;
      r_we       <= 1'b0;
      r_inr      <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rdata    <= '0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ram_we   <= 1'b0;
    end else begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata  <= '0;
      r_ram_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_ram_addr <= w_sel_addr;
            r_ram_din  <= w_sel_wdata;
            r_ram_we   <= w_sel_we & w_sel_inr;
            r_gnt_id   <= w_id;
            r_we       <= w_sel_we;
            r_inr      <= w_sel_inr;
            r_last_gnt <= w_id;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: r_state <= ST_RESP;
        ST_RESP: begin
          r_ack0  <= ~r_gnt_id;
          r_ack1  <= r_gnt_id;
          // Writes leave the RAM read bus floating, so only in-range reads forward it.
          r_rdata <= (!r_we && r_inr) ? i_ram_dout[DATA_W-1:0] : '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ack0     = r_ack0;
  assign o_ack1     = r_ack1;
  assign o_rdata    = r_rdata;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_ram_addr = r_ram_addr;
  assign o_ram_din  = r_ram_din;
  assign o_ram_we   = r_ram_we;

endmodule

// File: tb/tb_ram_b_arbiter.sv
// Bench for ram_b_arbiter: directed scenarios plus randomized two-port traffic checked
// against a transaction-level memory/arbitration model.
module tb_ram_b_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [19:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, busy, ram_we;
  logic [31:0] rdata, ram_din;
  logic [19:0] ram_addr;
  logic [47:0] ram_dout = '0;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem    [0:127];
  logic [31:0] refmem [0:127];
  logic        load_en = 1'b1;

  logic g_other_ack;
  logic g_we_seen;

  always #5 clk = ~clk;

  ram_b_arbiter dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req0     (req0),
    .i_req1     (req1),
    .i_we0      (we0),
    .i_we1      (we1),
    .i_addr0    (addr0),
    .i_addr1    (addr1),
    .i_wdata0   (wdata0),
    .i_wdata1   (wdata1),
    .o_ack0     (ack0),
    .o_ack1     (ack1),
    .o_rdata    (rdata),
    .o_busy     (busy),
    .o_ram_addr (ram_addr),
    .o_ram_din  (ram_din),
    .o_ram_we   (ram_we),
    .i_ram_dout (ram_dout)
  );

  function automatic logic [31:0] seed_word(input int i);
    return 32'hC0DE_0000 ^ (i * 32'h0001_9E37);
  endfunction

  // RAM model: 1-cycle registered read, bus floats during write cycles, junk in upper bits.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 128; i++) mem[i] <= seed_word(i);
    end else if (ram_we) begin
      mem[ram_addr[6:0]] <= ram_din;
      ram_dout <= 'z;
    end else begin
      ram_dout <= {16'hA5C3, mem[ram_addr[6:0]]};
    end
  end

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input int p, input logic rq, input logic we, input logic [19:0] a,
                       input logic [31:0] wd);
    if (p == 0) begin req0 = rq; we0 = we; addr0 = a; wdata0 = wd; end
    else        begin req1 = rq; we1 = we; addr1 = a; wdata1 = wd; end
  endtask

  function automatic logic [31:0] exp_rdata(input logic we, input logic [19:0] a);
    return (!we && a < 20'd128) ? refmem[a[6:0]] : 32'h0;
  endfunction

  // Called at a negedge; returns the data seen in the ack cycle and edges waited.
  task automatic access(input int p, input logic we, input logic [19:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat);
    logic done;
    done = 1'b0;
    rd = '0;
    lat = 0;
    g_other_ack = 1'b0;
    g_we_seen = 1'b0;
    drive(p, 1'b1, we, a, wd);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ram_we) g_we_seen = 1'b1;
      if ((p == 0 && ack1) || (p == 1 && ack0)) g_other_ack = 1'b1;
      if ((p == 0 && ack0) || (p == 1 && ack1)) begin
        done = 1'b1;
        rd = rdata;
      end
    end
    drive(p, 1'b0, 1'b0, '0, '0);
    if (!done) chk_eq("access_timeout", 64'(lat), 64'd3);
    if (done && we && a < 20'd128) refmem[a[6:0]] = wd;
  endtask

  logic [31:0] rd;
  int          lat;

  logic        pend [2];
  int          since [2];
  logic        r_we [2];
  logic [19:0] r_addr [2];
  logic [31:0] r_wd [2];

  initial begin
    int n;
    int last_ack;
    int must_next;
    int must_cyc;
    int p;
    int q;
    logic [31:0] exp72;

    for (int i = 0; i < 128; i++) refmem[i] = seed_word(i);

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    load_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_eq("rst_ack0", 64'(ack0), 64'd0);
    chk_eq("rst_ack1", 64'(ack1), 64'd0);
    chk_eq("rst_rdata", 64'(rdata), 64'd0);
    chk_eq("rst_busy", 64'(busy), 64'd0);
    chk_eq("rst_ram_we", 64'(ram_we), 64'd0);
    chk_eq("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk_eq("rst_ram_din", 64'(ram_din), 64'd0);

    // Both ports read continuously: first contention goes to port 0, then alternation.
    drive(0, 1'b1, 1'b0, 20'd10, 32'h0);
    drive(1, 1'b1, 1'b0, 20'd20, 32'h0);
    n = 0;
    for (int c = 1; c <= 16 && n < 4; c++) begin
      @(negedge clk);
      chk_eq("t3_ack_excl", 64'(ack0 & ack1), 64'd0);
      if (ack0 || ack1) begin
        p = ack1 ? 1 : 0;
        chk_eq("t3_order", 64'(p), 64'(n % 2));
        chk_eq("t3_cycle", 64'(c), 64'(3 + 3 * n));
        chk_eq("t3_rdata", 64'(rdata), 64'(refmem[p == 1 ? 20 : 10]));
        n++;
        if (n == 4) begin
          drive(0, 1'b0, 1'b0, '0, '0);
          drive(1, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    chk_eq("t3_count", 64'(n), 64'd4);
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);

    // Port 0 write then read back.
    access(0, 1'b1, 20'd5, 32'hDEADBEEF, rd, lat);
    chk_eq("t2_wr_lat", 64'(lat), 64'd3);
    chk_eq("t2_wr_we_seen", 64'(g_we_seen), 64'd1);
    chk_eq("t2_wr_no_ack1", 64'(g_other_ack), 64'd0);
    chk_eq("t5_wr_rdata", 64'(rd), 64'd0);
    chk_eq("t5_wr_known", 64'($isunknown(rd)), 64'd0);
    access(0, 1'b0, 20'd5, 32'h0, rd, lat);
    chk_eq("t2_rd_lat", 64'(lat), 64'd3);
    chk_eq("t2_rd_data", 64'(rd), 64'hDEADBEEF);
    chk_eq("t2_rd_no_ack1", 64'(g_other_ack), 64'd0);

    // Out-of-range write and read on port 1; aliased word 72 must be untouched.
    exp72 = refmem[72];
    access(1, 1'b1, 20'd200, 32'h1234, rd, lat);
    chk_eq("t4_wr_lat", 64'(lat), 64'd3);
    chk_eq("t4_wr_no_ram_we", 64'(g_we_seen), 64'd0);
    chk_eq("t4_wr_rdata", 64'(rd), 64'd0);
    access(1, 1'b0, 20'd200, 32'h0, rd, lat);
    chk_eq("t4_rd_lat", 64'(lat), 64'd3);
    chk_eq("t4_rd_data", 64'(rd), 64'd0);
    access(1, 1'b0, 20'd72, 32'h0, rd, lat);
    chk_eq("t4_word72", 64'(rd), 64'(exp72));

    // Reset during ISSUE of a port 1 read drops the access.
    drive(1, 1'b1, 1'b0, 20'd33, 32'h0);
    @(negedge clk);
    chk_eq("t6_busy_issue", 64'(busy), 64'd1);
    rst = 1'b1;
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    chk_eq("t6_busy_rst", 64'(busy), 64'd0);
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack1 || ack0 || busy) n++;
    end
    chk_eq("t6_no_activity", 64'(n), 64'd0);
    access(0, 1'b0, 20'd0, 32'h0, rd, lat);
    chk_eq("t6_rd_lat", 64'(lat), 64'd3);
    chk_eq("t6_rd_data", 64'(rd), 64'(refmem[0]));

    // Random two-port traffic against the transaction model.
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; since[i] = 0; r_we[i] = 1'b0; r_addr[i] = '0; r_wd[i] = '0;
    end
    last_ack = -100;
    must_next = -1;
    must_cyc = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      chk_eq("rnd_ack_excl", 64'(ack0 & ack1), 64'd0);
      if (ram_we) chk_eq("rnd_we_in_range", 64'(ram_addr < 20'd128), 64'd1);
      for (int pp = 0; pp < 2; pp++) begin
        if ((pp == 0 && ack0) || (pp == 1 && ack1)) begin
          chk_eq("rnd_ack_pending", 64'(pend[pp]), 64'd1);
          chk_eq("rnd_ack_gap", 64'(k - last_ack >= 3), 64'd1);
          if (must_next >= 0) begin
            chk_eq("rnd_rr_order", 64'(pp), 64'(must_next));
            chk_eq("rnd_rr_time", 64'(k), 64'(must_cyc));
            must_next = -1;
          end
          if (pend[pp]) begin
            chk_eq("rnd_rdata", 64'(rdata), 64'(exp_rdata(r_we[pp], r_addr[pp])));
            if (r_we[pp] && r_addr[pp] < 20'd128) refmem[r_addr[pp][6:0]] = r_wd[pp];
          end
          pend[pp] = 1'b0;
          last_ack = k;
          q = 1 - pp;
          if (pend[q]) begin
            must_next = q;
            must_cyc = k + 3;
          end
        end else if (pend[pp] && k - since[pp] > 6) begin
          chk_eq("rnd_ack_timeout", 64'(k - since[pp]), 64'd6);
          pend[pp] = 1'b0;
          must_next = -1;
        end
      end
      for (int pp = 0; pp < 2; pp++) begin
        if (!pend[pp]) begin
          if ($urandom_range(0, 2) == 0 && k < 580) begin
            r_we[pp] = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
              0:       r_addr[pp] = 20'(128 + $urandom_range(0, 1000));
              1:       r_addr[pp] = 20'd127;
              2:       r_addr[pp] = 20'hFFFFF;
              3:       r_addr[pp] = 20'd128;
              default: r_addr[pp] = 20'($urandom_range(0, 15));
            endcase
            r_wd[pp] = $urandom;
            pend[pp] = 1'b1;
            since[pp] = k;
            drive(pp, 1'b1, r_we[pp], r_addr[pp], r_wd[pp]);
          end else begin
            drive(pp, 1'b0, 1'b0, '0, '0);
          end
        end
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (8) @(negedge clk);
    chk_eq("end_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
